det_event_fifo: RTL



---
 rtl/det_pkg.sv | 21 ++
 rtl/det_ts_fifo.sv | 67 ++++++
 rtl/det_event_fifo.sv | 91 +++++++++
 3 files changed

// File: rtl/det_pkg.sv
// Shared constants, width helpers and the timestamp type used by the
// detection timestamp FIFO and its sub-module.
package det_pkg;

    localparam int DET_DEPTH_DEF = 8;
    localparam int DET_TS_W_DEF  = 16;
    localparam int DET_CNT_W_DEF = 8;

    // Pointers wrap naturally, so they are exactly log2(DEPTH) bits wide.
    function automatic int det_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // The level must represent 0..DEPTH inclusive.
    function automatic int det_lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [DET_TS_W_DEF-1:0] det_ts_t;

endpackage

// File: rtl/det_ts_fifo.sv
// First-word-fall-through FIFO holding detection timestamps.
// A push is accepted when not full, or when full and a pop happens in the same cycle.
module det_ts_fifo
    import det_pkg::*;
#(
    parameter int DEPTH = DET_DEPTH_DEF,
    parameter int W     = DET_TS_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       valid_o,
    output logic                       accept_o,
    output logic [det_lvl_w(DEPTH)-1:0] level_o
);

    localparam int PTR_W = det_ptr_w(DEPTH);
    localparam int LVL_W = det_lvl_w(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty, full, pop_ok, push_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
        else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o  = ~empty;
    assign accept_o = push_ok;
    assign level_o  = level_q;

endmodule

// File: rtl/det_event_fifo.sv
// Timestamps 1101-detector pulses, queues them in a FWFT FIFO and accounts for drops.
// Optional DET_TOTAL_CNT_EN adds a wrapping 32-bit count of all detection cycles.
module det_event_fifo
    import det_pkg::*;
#(
    parameter int DEPTH = DET_DEPTH_DEF,
    parameter int TS_W  = DET_TS_W_DEF,
    parameter int CNT_W = DET_CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        det_in,
    output logic [TS_W-1:0]             out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [det_lvl_w(DEPTH)-1:0] level,
    output logic                        ovf,
    output logic [CNT_W-1:0]            drop_cnt,
    input  logic                        clr_ovf
`ifdef DET_TOTAL_CNT_EN
    ,
    output logic [31:0]                 total_cnt
`endif
);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             accept, drop;

    det_ts_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_i   (det_in),
        .pop_i    (out_ready),
        .wdata_i  (ts_q),
        .rdata_o  (out_data),
        .valid_o  (out_valid),
        .accept_o (accept),
        .level_o  (level)
    );

    assign drop = det_in & ~accept;
    assign ts_d = ts_q + 1'b1;

    // Clear is applied first so a drop in the same cycle wins.
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q       <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

`ifdef DET_TOTAL_CNT_EN
    logic [31:0] total_q, total_d;

    assign total_d = det_in ? total_q + 32'd1 : total_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) total_q <= '0;
        else          total_q <= total_d;
    end

    assign total_cnt = total_q;
`endif

endmodule
